// File: rtl/convolve_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | convolve_ctrl: raster sequencer and coefficient owner for the convolution |
// | kernel; streams a frame, then flushes zero pixels to drain trailing rows. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module convolve_ctrl #(
  parameter int KRNL_SZ   = 5,
  parameter int ROW_SZ    = 320,
  parameter int COL_SZ    = 240,
  parameter int FLUSH_LEN = ROW_SZ*(KRNL_SZ/2)+(KRNL_SZ/2)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  input  logic [7:0]                   src_val,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic                         cfg_we,
  input  logic [4:0]                   cfg_addr,
  input  logic [7:0]                   cfg_data,
  output logic [7:0]                   cv_in_val,
  output logic [9:0]                   cv_in_x,
  output logic [9:0]                   cv_in_y,
  output logic                         cv_is_in_val,
  output logic [KRNL_SZ*KRNL_SZ*8-1:0] kernel,
  output logic [15:0]                  frame_cnt
);

  localparam int          NCOEF  = KRNL_SZ*KRNL_SZ;
  localparam int          AW     = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int          FCW    = $clog2(FLUSH_LEN + 1);
  localparam logic [9:0]  X_LAST = 10'(ROW_SZ - 1);
  localparam logic [9:0]  Y_LAST = 10'(COL_SZ - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [9:0]               x_q, x_d, y_q, y_d;
  logic [FCW-1:0]           flush_cnt_q, flush_cnt_d;
  logic [NCOEF-1:0][7:0]    shadow_q, shadow_d, active_q, active_d;
  logic [7:0]               cv_in_val_q, cv_in_val_d;
  logic [9:0]               cv_in_x_q, cv_in_x_d, cv_in_y_q, cv_in_y_d;
  logic                     cv_is_in_val_q, cv_is_in_val_d;
  logic                     done_q, done_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic                     w_accept, w_push, w_x_wrap, w_last_pix;
  logic [9:0]               w_x_nxt, w_y_nxt;

  assign src_ready  = (state_q == S_STREAM);
  assign w_accept   = src_valid & src_ready;
  assign w_push     = w_accept | (state_q == S_FLUSH);
  assign w_x_wrap   = (x_q == X_LAST);
  assign w_last_pix = w_x_wrap & (y_q == Y_LAST);
  assign w_x_nxt    = w_x_wrap ? 10'd0 : x_q + 10'd1;
  assign w_y_nxt    = w_x_wrap ? ((y_q == Y_LAST) ? 10'd0 : y_q + 10'd1) : y_q;

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    flush_cnt_d    = flush_cnt_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    cv_in_val_d    = cv_in_val_q;
    cv_in_x_d      = cv_in_x_q;
    cv_in_y_d      = cv_in_y_q;
    cv_is_in_val_d = 1'b0;
    done_d         = 1'b0;
    frame_cnt_d    = frame_cnt_q;

    if (cfg_we && ({27'd0, cfg_addr} < 32'(NCOEF))) begin
      shadow_d[cfg_addr[AW-1:0]] = cfg_data;
    end

    if (w_push) begin
      cv_is_in_val_d = 1'b1;
      cv_in_val_d    = (state_q == S_FLUSH) ? 8'd0 : src_val;
      cv_in_x_d      = x_q;
      cv_in_y_d      = y_q;
      x_d            = w_x_nxt;
      y_d            = w_y_nxt;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Commit uses shadow_d so a write landing in this very cycle is kept.
        active_d    = shadow_d;
        x_d         = 10'd0;
        y_d         = 10'd0;
        flush_cnt_d = '0;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        if (w_accept && w_last_pix) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FCW'(FLUSH_LEN - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d        = S_IDLE;
      x_d            = 10'd0;
      y_d            = 10'd0;
      flush_cnt_d    = '0;
      active_d       = active_q;
      cv_in_val_d    = cv_in_val_q;
      cv_in_x_d      = cv_in_x_q;
      cv_in_y_d      = cv_in_y_q;
      cv_is_in_val_d = 1'b0;
      done_d         = 1'b0;
      frame_cnt_d    = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      x_q            <= 10'd0;
      y_q            <= 10'd0;
      flush_cnt_q    <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      cv_in_val_q    <= 8'd0;
      cv_in_x_q      <= 10'd0;
      cv_in_y_q      <= 10'd0;
      cv_is_in_val_q <= 1'b0;
      done_q         <= 1'b0;
      frame_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      flush_cnt_q    <= flush_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      cv_in_val_q    <= cv_in_val_d;
      cv_in_x_q      <= cv_in_x_d;
      cv_in_y_q      <= cv_in_y_d;
      cv_is_in_val_q <= cv_is_in_val_d;
      done_q         <= done_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign cv_in_val    = cv_in_val_q;
  assign cv_in_x      = cv_in_x_q;
  assign cv_in_y      = cv_in_y_q;
  assign cv_is_in_val = cv_is_in_val_q;
  assign kernel       = active_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_convolve_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_convolve_ctrl: directed frames on a 3x3 / 8x4 configuration.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_convolve_ctrl;

  localparam int K   = 3;
  localparam int ROW = 8;
  localparam int COL = 4;
  localparam int FL  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_val = 8'd0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = 5'd0;
  logic [7:0]  cfg_data = 8'd0;
  logic        busy, done, src_ready, cv_is_in_val;
  logic [7:0]  cv_in_val;
  logic [9:0]  cv_in_x, cv_in_y;
  logic [K*K*8-1:0] kernel;
  logic [15:0] frame_cnt;

  int          n_vec = 0;
  int          n_bad = 0;
  int          ex, ey;
  logic [15:0] fc_exp = 16'd0;
  logic [71:0] kexp;

  convolve_ctrl #(
    .KRNL_SZ(K), .ROW_SZ(ROW), .COL_SZ(COL), .FLUSH_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .src_val(src_val), .src_valid(src_valid), .src_ready(src_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cv_in_val(cv_in_val), .cv_in_x(cv_in_x), .cv_in_y(cv_in_y),
    .cv_is_in_val(cv_is_in_val), .kernel(kernel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    if (ex == ROW-1) begin
      ex = 0;
      ey = (ey == COL-1) ? 0 : ey + 1;
    end else begin
      ex++;
    end
  endtask

  task automatic exp_push(input logic [7:0] v);
    chk("push_vld", 128'(cv_is_in_val), 128'(1));
    chk("push_val", 128'(cv_in_val), 128'(v));
    chk("push_x", 128'(cv_in_x), 128'(ex));
    chk("push_y", 128'(cv_in_y), 128'(ey));
    adv();
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // gap: src_valid pattern 1,0,0,1; abort_at: accept count at which abort fires (-1 none)
  task automatic run_frame(input bit gap, input int abort_at, input bit mid_ops,
                           input bit load_ops, input bit rst_flush, input logic [71:0] kx);
    logic [7:0] pix;
    bit         v;
    int         n;
    int         cyc;
    chk("idle_busy", 128'(busy), 128'(0));
    start = 1'b1;
    if (load_ops) begin cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 8'h22; end
    @(negedge clk);
    start = 1'b0;
    if (load_ops) begin cfg_addr = 5'd8; cfg_data = 8'h33; end
    else cfg_we = 1'b0;
    chk("load_busy", 128'(busy), 128'(1));
    chk("load_rdy", 128'(src_ready), 128'(0));
    @(negedge clk);
    cfg_we = 1'b0;
    chk("kernel_commit", 128'(kernel), 128'(kx));
    ex = 0; ey = 0; n = 0; cyc = 0;
    while (n < ROW*COL && cyc < 400) begin
      v   = !gap || (cyc % 4 == 0) || (cyc % 4 == 3);
      pix = 8'(n*37) | 8'h01;
      chk("stream_rdy", 128'(src_ready), 128'(1));
      src_valid = v; src_val = pix;
      if (mid_ops && cyc == 3) begin cfg_we = 1'b1; cfg_addr = 5'd4; cfg_data = 8'hF0; end
      if (mid_ops && cyc == 4) begin cfg_we = 1'b1; cfg_addr = 5'd9; cfg_data = 8'h55; end
      if (mid_ops && cyc == 6) start = 1'b1;
      if (abort_at >= 0 && n == abort_at) abort = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0; src_valid = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_vld", 128'(cv_is_in_val), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_fcnt", 128'(frame_cnt), 128'(fc_exp));
        chk("abort_kernel", 128'(kernel), 128'(kx));
        return;
      end
      if (v) begin
        exp_push(pix);
        n++;
      end else begin
        chk("gap_vld", 128'(cv_is_in_val), 128'(0));
      end
      cyc++;
    end
    chk("stream_count", 128'(n), 128'(ROW*COL));
    chk("kernel_hold", 128'(kernel), 128'(kx));
    for (int k = 1; k <= FL; k++) begin
      chk("flush_rdy", 128'(src_ready), 128'(0));
      if (rst_flush && k == 5) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_vld", 128'(cv_is_in_val), 128'(0));
        chk("rst_x", 128'(cv_in_x), 128'(0));
        chk("rst_y", 128'(cv_in_y), 128'(0));
        chk("rst_kernel", 128'(kernel), 128'(0));
        chk("rst_fcnt", 128'(frame_cnt), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        fc_exp = 16'd0;
        @(negedge clk);
        chk("rel_busy", 128'(busy), 128'(0));
        chk("rel_done", 128'(done), 128'(0));
        return;
      end
      @(negedge clk);
      exp_push(8'd0);
      chk("flush_done", 128'(done), 128'(k == FL));
      chk("flush_busy", 128'(busy), 128'(1));
    end
    fc_exp = fc_exp + 16'd1;
    chk("done_fcnt", 128'(frame_cnt), 128'(fc_exp));
    @(negedge clk);
    chk("post_busy", 128'(busy), 128'(0));
    chk("post_done", 128'(done), 128'(0));
    chk("post_vld", 128'(cv_is_in_val), 128'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy0", 128'(busy), 128'(0));
    chk("rst_done0", 128'(done), 128'(0));
    chk("rst_rdy0", 128'(src_ready), 128'(0));
    chk("rst_vld0", 128'(cv_is_in_val), 128'(0));
    chk("rst_kernel0", 128'(kernel), 128'(0));
    chk("rst_fcnt0", 128'(frame_cnt), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < K*K; i++) cfg_write(5'(i), 8'h10);
    kexp = {9{8'h10}};
    run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0, kexp);
    run_frame(1'b1, -1, 1'b1, 1'b0, 1'b0, kexp);
    kexp[39:32] = 8'hF0;
    run_frame(1'b0, 13, 1'b0, 1'b0, 1'b0, kexp);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("startabort_busy2", 128'(busy), 128'(0));
    chk("startabort_fcnt", 128'(frame_cnt), 128'(fc_exp));
    kexp[7:0]   = 8'h22;
    kexp[71:64] = 8'h33;
    run_frame(1'b0, -1, 1'b0, 1'b1, 1'b0, kexp);
    run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1, kexp);
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
